// File: rtl/udm_rx_frontend.sv
// UART receive front end for the UDM link: synchronizer, bit-level receiver and sync/escape deframer.
// Optional even-parity bit after bit 7 is enabled by defining UDM_RX_PARITY_EN.
module udm_rx_frontend #(
    parameter int BITPERIOD_W   = 32,
    parameter int MIN_BITPERIOD = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   rx_i,
    input  logic [BITPERIOD_W-1:0] bitperiod_i,
    output logic [7:0]             rx_data_o,
    output logic                   rx_sync_o,
    output logic                   rx_valid_o,
    input  logic                   rx_ready_i,
    output logic                   err_frame_o,
    output logic                   err_overrun_o,
    output logic                   err_parity_o
);

    localparam logic [7:0]             SYNC_BYTE  = 8'h55;
    localparam logic [7:0]             ESC_BYTE   = 8'h5A;
    localparam logic [BITPERIOD_W-1:0] MIN_PERIOD = BITPERIOD_W'(MIN_BITPERIOD);
    localparam logic [BITPERIOD_W-1:0] ONE        = BITPERIOD_W'(1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
`ifdef UDM_RX_PARITY_EN
        PARITY    = 3'd3,
`endif
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } rx_state_t;

`ifdef UDM_RX_PARITY_EN
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`endif

    logic                   sync1_r;
    logic                   sync2_r;
    logic                   prev_r;
    rx_state_t              state_r;
    rx_state_t              state_nx_s;
    logic [BITPERIOD_W-1:0] period_r;
    logic [BITPERIOD_W-1:0] period_nx_s;
    logic [BITPERIOD_W-1:0] period_in_s;
    logic [BITPERIOD_W-1:0] cnt_r;
    logic [BITPERIOD_W-1:0] cnt_nx_s;
    logic [2:0]             bit_cnt_r;
    logic [2:0]             bit_cnt_nx_s;
    logic [7:0]             shift_r;
    logic [7:0]             shift_nx_s;
    logic                   fall_s;
    logic                   expire_s;
    logic                   byte_done_s;
    logic                   frame_err_s;
    logic                   par_err_s;
    logic                   esc_r;
    logic                   esc_nx_s;
    logic                   emit_s;
    logic                   emit_sync_s;
    logic [7:0]             rx_data_r;
    logic                   rx_sync_r;
    logic                   rx_valid_r;
    logic                   err_frame_r;
    logic                   err_overrun_r;
`ifdef UDM_RX_PARITY_EN
    logic                   par_bad_r;
    logic                   par_bad_nx_s;
    logic                   err_parity_r;
`endif

    assign fall_s   = prev_r & ~sync2_r;
    assign expire_s = (cnt_r == '0);

    // Clamp the requested bit period to the smallest period the sampler can handle
    always_comb begin
        if (bitperiod_i < MIN_PERIOD) begin
            period_in_s = MIN_PERIOD;
        end else begin
            period_in_s = bitperiod_i;
        end
    end

    // Line synchronizer; flops idle high so reset never fakes a falling edge
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            prev_r  <= 1'b1;
        end else begin
            sync1_r <= rx_i;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // Receive FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Receive FSM next state, bit sampling and per-frame event strobes
    always_comb begin
        state_nx_s   = state_r;
        period_nx_s  = period_r;
        cnt_nx_s     = cnt_r;
        bit_cnt_nx_s = bit_cnt_r;
        shift_nx_s   = shift_r;
        byte_done_s  = 1'b0;
        frame_err_s  = 1'b0;
        par_err_s    = 1'b0;
`ifdef UDM_RX_PARITY_EN
        par_bad_nx_s = par_bad_r;
`endif
        case (state_r)
            IDLE: begin
                if (fall_s) begin
                    state_nx_s   = START;
                    period_nx_s  = period_in_s;
                    cnt_nx_s     = period_in_s >> 1;
                    bit_cnt_nx_s = 3'd0;
`ifdef UDM_RX_PARITY_EN
                    par_bad_nx_s = 1'b0;
`endif
                end else begin
                    state_nx_s = IDLE;
                end
            end
            START: begin
                if (!expire_s) begin
                    cnt_nx_s = cnt_r - ONE;
                end else if (sync2_r) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DATA;
                    cnt_nx_s   = period_r - ONE;
                end
            end
            DATA: begin
                if (!expire_s) begin
                    cnt_nx_s = cnt_r - ONE;
                end else begin
                    shift_nx_s = {sync2_r, shift_r[7:1]};
                    cnt_nx_s   = period_r - ONE;
                    if (bit_cnt_r == 3'd7) begin
`ifdef UDM_RX_PARITY_EN
                        state_nx_s = PARITY;
`else
                        state_nx_s = STOP;
`endif
                    end else begin
                        bit_cnt_nx_s = bit_cnt_r + 3'd1;
                    end
                end
            end
`ifdef UDM_RX_PARITY_EN
            PARITY: begin
                if (!expire_s) begin
                    cnt_nx_s = cnt_r - ONE;
                end else begin
                    par_bad_nx_s = even_parity(shift_r) ^ sync2_r;
                    par_err_s    = even_parity(shift_r) ^ sync2_r;
                    cnt_nx_s     = period_r - ONE;
                    state_nx_s   = STOP;
                end
            end
`endif
            STOP: begin
                if (!expire_s) begin
                    cnt_nx_s = cnt_r - ONE;
                end else if (sync2_r) begin
`ifdef UDM_RX_PARITY_EN
                    byte_done_s = ~par_bad_r;
`else
                    byte_done_s = 1'b1;
`endif
                    state_nx_s  = IDLE;
                end else begin
                    frame_err_s = 1'b1;
                    state_nx_s  = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (sync2_r) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = WAIT_HIGH;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Receive datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            period_r  <= '0;
            cnt_r     <= '0;
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
        end else begin
            period_r  <= period_nx_s;
            cnt_r     <= cnt_nx_s;
            bit_cnt_r <= bit_cnt_nx_s;
            shift_r   <= shift_nx_s;
        end
    end

`ifdef UDM_RX_PARITY_EN
    // Parity verdict for the frame in flight, plus its error pulse
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            par_bad_r    <= 1'b0;
            err_parity_r <= 1'b0;
        end else begin
            par_bad_r    <= par_bad_nx_s;
            err_parity_r <= par_err_s;
        end
    end

    assign err_parity_o = err_parity_r;
`else
    assign err_parity_o = 1'b0;
`endif

    // Deframer: an escape byte marks the following byte as literal data
    always_comb begin
        emit_s      = 1'b0;
        emit_sync_s = 1'b0;
        esc_nx_s    = esc_r;
        if (byte_done_s) begin
            if (esc_r) begin
                emit_s   = 1'b1;
                esc_nx_s = 1'b0;
            end else if (shift_r == ESC_BYTE) begin
                esc_nx_s = 1'b1;
            end else begin
                emit_s      = 1'b1;
                emit_sync_s = (shift_r == SYNC_BYTE);
                esc_nx_s    = 1'b0;
            end
        end else if (frame_err_s || par_err_s) begin
            esc_nx_s = 1'b0;
        end else begin
            esc_nx_s = esc_r;
        end
    end

    // Output holding register; a byte arriving while one is still held is dropped
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            esc_r         <= 1'b0;
            rx_data_r     <= 8'h00;
            rx_sync_r     <= 1'b0;
            rx_valid_r    <= 1'b0;
            err_frame_r   <= 1'b0;
            err_overrun_r <= 1'b0;
        end else begin
            esc_r         <= esc_nx_s;
            err_frame_r   <= frame_err_s;
            err_overrun_r <= 1'b0;
            if (emit_s && rx_valid_r && !rx_ready_i) begin
                err_overrun_r <= 1'b1;
            end else if (emit_s) begin
                rx_data_r  <= shift_r;
                rx_sync_r  <= emit_sync_s;
                rx_valid_r <= 1'b1;
            end else if (rx_valid_r && rx_ready_i) begin
                rx_valid_r <= 1'b0;
            end else begin
                rx_valid_r <= rx_valid_r;
            end
        end
    end

    assign rx_data_o     = rx_data_r;
    assign rx_sync_o     = rx_sync_r;
    assign rx_valid_o    = rx_valid_r;
    assign err_frame_o   = err_frame_r;
    assign err_overrun_o = err_overrun_r;

endmodule

// File: tb/tb_udm_rx_frontend.sv
// Randomized bench for udm_rx_frontend: UART frames are generated bit by bit and the
// expected byte stream / error counts come from a frame-level deframer model.
module tb_udm_rx_frontend;

`ifdef UDM_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        rx_i = 1'b1;
    logic [31:0] bitperiod_i = 32'd16;
    logic [7:0]  rx_data_o;
    logic        rx_sync_o;
    logic        rx_valid_o;
    logic        rx_ready_i = 1'b1;
    logic        err_frame_o;
    logic        err_overrun_o;
    logic        err_parity_o;

    always #5 clk_i = ~clk_i;

    udm_rx_frontend #(.BITPERIOD_W(32), .MIN_BITPERIOD(4)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .rx_i          (rx_i),
        .bitperiod_i   (bitperiod_i),
        .rx_data_o     (rx_data_o),
        .rx_sync_o     (rx_sync_o),
        .rx_valid_o    (rx_valid_o),
        .rx_ready_i    (rx_ready_i),
        .err_frame_o   (err_frame_o),
        .err_overrun_o (err_overrun_o),
        .err_parity_o  (err_parity_o)
    );

    int n_vec = 0;
    int n_err = 0;
    int n_xfer = 0, n_valid_cyc = 0, n_frame = 0, n_ovr = 0, n_par = 0;
    int exp_frame = 0, exp_ovr = 0, exp_par = 0;
    logic [8:0] exp_q[$];
    bit m_esc = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: transfers, hold stability and error pulse counting
    logic [8:0] prev_out = 9'h000;
    bit         prev_hold = 1'b0;
    always @(negedge clk_i) begin
        if (err_frame_o)   n_frame++;
        if (err_overrun_o) n_ovr++;
        if (err_parity_o)  n_par++;
        if (!rst_i) begin
            if (prev_hold) begin
                check_val("hold_valid", 32'(rx_valid_o), 32'd1);
                check_val("hold_data", 32'({rx_sync_o, rx_data_o}), 32'(prev_out));
            end
            if (rx_valid_o) n_valid_cyc++;
            if (rx_valid_o && rx_ready_i) begin
                n_xfer++;
                check_val("out_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    check_val("out_byte", 32'({rx_sync_o, rx_data_o}), 32'(exp_q[0]));
                    exp_q.delete(0);
                end
            end
            prev_hold = rx_valid_o && !rx_ready_i;
            prev_out  = {rx_sync_o, rx_data_o};
        end else begin
            prev_hold = 1'b0;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic drive_bit(input logic v, input int p);
        rx_i = v;
        wait_cyc(p);
    endtask

    // Frame-level deframer reference: escape, sync tag, overrun drop, error accounting
    task automatic model_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok);
        if (!par_ok) exp_par++;
        if (!stop_ok) exp_frame++;
        if (!stop_ok || !par_ok) begin
            m_esc = 1'b0;
        end else if (!m_esc && b == 8'h5A) begin
            m_esc = 1'b1;
        end else begin
            if (!rx_ready_i && exp_q.size() > 0) exp_ovr++;
            else exp_q.push_back({!m_esc && b == 8'h55, b});
            m_esc = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok, input int p);
        model_frame(b, stop_ok, par_ok);
        drive_bit(1'b0, p);
        for (int i = 0; i < 8; i++) drive_bit(b[i], p);
        if (PAR_EN) drive_bit((^b) ^ !par_ok, p);
        drive_bit(stop_ok, p);
        drive_bit(1'b1, 2 * p + 4);
    endtask

    initial begin
        int p, x0, f0, o0, pe0, v0, glen;
        logic [7:0] b;
        bit stop_ok, par_ok;

        wait_cyc(5);
        check_val("rst_outs", 32'({rx_valid_o, rx_sync_o, rx_data_o, err_frame_o, err_overrun_o, err_parity_o}), 32'd0);
        rst_i = 1'b0;
        wait_cyc(5);
        check_val("idle_valid", 32'(rx_valid_o), 32'd0);

        // basic byte at 434 cycles/bit
        bitperiod_i = 32'd434;
        x0 = n_xfer; v0 = n_valid_cyc;
        send_frame(8'h81, 1'b1, 1'b1, 434);
        check_val("b81_xfer", 32'(n_xfer - x0), 32'd1);
        check_val("b81_vcyc", 32'(n_valid_cyc - v0), 32'd1);

        // sync token, then escaped sync
        bitperiod_i = 32'd16;
        x0 = n_xfer;
        send_frame(8'h55, 1'b1, 1'b1, 16);
        send_frame(8'h5A, 1'b1, 1'b1, 16);
        send_frame(8'h55, 1'b1, 1'b1, 16);
        check_val("esc_xfer", 32'(n_xfer - x0), 32'd2);

        // overrun with consumer stalled
        rx_ready_i = 1'b0;
        x0 = n_xfer; o0 = n_ovr;
        send_frame(8'hAA, 1'b1, 1'b1, 16);
        send_frame(8'hBB, 1'b1, 1'b1, 16);
        check_val("ovr_data", 32'({rx_valid_o, rx_data_o}), 32'h1AA);
        check_val("ovr_pulse", 32'(n_ovr - o0), 32'd1);
        rx_ready_i = 1'b1;
        wait_cyc(20);
        check_val("ovr_xfer", 32'(n_xfer - x0), 32'd1);

        // framing error then recovery
        x0 = n_xfer; f0 = n_frame;
        send_frame(8'h12, 1'b0, 1'b1, 16);
        check_val("frm_pulse", 32'(n_frame - f0), 32'd1);
        check_val("frm_xfer", 32'(n_xfer - x0), 32'd0);
        send_frame(8'h34, 1'b1, 1'b1, 16);
        check_val("frm_recover", 32'(n_xfer - x0), 32'd1);

`ifdef UDM_RX_PARITY_EN
        x0 = n_xfer; pe0 = n_par;
        send_frame(8'h03, 1'b1, 1'b0, 16);
        check_val("par_pulse", 32'(n_par - pe0), 32'd1);
        check_val("par_drop", 32'(n_xfer - x0), 32'd0);
        send_frame(8'h03, 1'b1, 1'b1, 16);
        check_val("par_good", 32'(n_xfer - x0), 32'd1);
`endif

        // glitch, then reset in the middle of bit 3
        bitperiod_i = 32'd434;
        x0 = n_xfer; f0 = n_frame; o0 = n_ovr; pe0 = n_par; v0 = n_valid_cyc;
        drive_bit(1'b0, 100);
        drive_bit(1'b1, 600);
        drive_bit(1'b0, 434);
        drive_bit(1'b1, 434);
        drive_bit(1'b0, 434);
        drive_bit(1'b1, 434);
        drive_bit(1'b0, 200);
        rst_i = 1'b1;
        rx_i  = 1'b1;
        wait_cyc(4);
        check_val("midrst_outs", 32'({rx_valid_o, err_frame_o, err_overrun_o, err_parity_o}), 32'd0);
        rst_i = 1'b0;
        m_esc = 1'b0;
        wait_cyc(1000);
        check_val("glitch_rst_vcyc", 32'(n_valid_cyc - v0), 32'd0);
        check_val("glitch_rst_errs", 32'((n_frame - f0) + (n_ovr - o0) + (n_par - pe0)), 32'd0);

        // randomized frames, glitches, periods and consumer stalls
        for (int it = 0; it < 80; it++) begin
            p = $urandom_range(4, 16);
            if (p == 4 && $urandom_range(0, 1) == 1) bitperiod_i = 32'($urandom_range(0, 3));
            else bitperiod_i = 32'(p);
            if ($urandom_range(0, 3) == 0) begin
                rx_ready_i = ~rx_ready_i;
                wait_cyc(4);
            end
            if ($urandom_range(0, 9) == 0) begin
                glen = $urandom_range(1, p / 2);
                drive_bit(1'b0, glen);
                drive_bit(1'b1, p + 6);
            end else begin
                case ($urandom_range(0, 3))
                    0:       b = 8'h55;
                    1:       b = 8'h5A;
                    default: b = 8'($urandom);
                endcase
                stop_ok = ($urandom_range(0, 9) != 0);
                par_ok  = PAR_EN ? ($urandom_range(0, 6) != 0) : 1'b1;
                send_frame(b, stop_ok, par_ok, p);
            end
        end

        rx_ready_i = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() > 0; i++) wait_cyc(1);
        wait_cyc(10);
        check_val("drain", 32'(exp_q.size()), 32'd0);
        check_val("frame_cnt", 32'(n_frame), 32'(exp_frame));
        check_val("ovr_cnt", 32'(n_ovr), 32'(exp_ovr));
        check_val("par_cnt", 32'(n_par), 32'(exp_par));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
